// File: rtl/calc_pkg.sv
// Shared definitions for the dot-product job sequencer: default widths,
// FSM state encoding and the sequencer's own load-register depth.
package calc_pkg;

  localparam int DATA_W_DEF  = 128;
  localparam int SUM_W_DEF   = 20;
  localparam int LOAD_STAGES = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/calc_tag_pipe.sv
// LAT-stage valid shift register: marks which datapath output cycles
// carry a sum belonging to a live beat.
module calc_tag_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic stage_reg [LAT];

  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= in_valid;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign out_valid = stage_reg[LAT-1];

endmodule

// File: rtl/calc_sequencer.sv
// Job controller for the sliced dot-product datapath: feeds N operand pairs,
// accumulates the N returned per-beat sums and hands out one wide result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SUM_W    = SUM_W_DEF,
  parameter int CALC_LAT = 2,
  parameter int CNT_W    = 8,
  parameter int ACC_W    = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_beats,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] calc_a,
  output logic [DATA_W-1:0] calc_b,
  output logic              calc_load,
  input  logic [SUM_W-1:0]  calc_sum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);

  // A full-length job of maximal sums must fit without wrapping.
  if (ACC_W < SUM_W + CNT_W) begin : g_acc_w_check
    $error("calc_sequencer: ACC_W must be >= SUM_W + CNT_W");
  end
  if (CALC_LAT < LOAD_STAGES) begin : g_lat_check
    $error("calc_sequencer: CALC_LAT must be >= 1");
  end

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  beats_reg, beats_next;
  logic [CNT_W-1:0]  issued_reg, issued_next;
  logic [CNT_W-1:0]  returned_reg, returned_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [DATA_W-1:0] calc_a_reg, calc_a_next;
  logic [DATA_W-1:0] calc_b_reg, calc_b_next;
  logic              calc_load_reg, calc_load_next;
  logic              tag_out;
  logic              accept;
  logic              beat_return;

  calc_tag_pipe #(
    .LAT (CALC_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (calc_load_reg),
    .out_valid (tag_out)
  );

  assign op_ready    = (state_reg == FEED) && (issued_reg < beats_reg);
  assign accept      = op_valid && op_ready;
  // Tags outside FEED/DRAIN can only be stale and are never accumulated.
  assign beat_return = tag_out && ((state_reg == FEED) || (state_reg == DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      beats_reg     <= '0;
      issued_reg    <= '0;
      returned_reg  <= '0;
      acc_reg       <= '0;
      calc_a_reg    <= '0;
      calc_b_reg    <= '0;
      calc_load_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beats_reg     <= beats_next;
      issued_reg    <= issued_next;
      returned_reg  <= returned_next;
      acc_reg       <= acc_next;
      calc_a_reg    <= calc_a_next;
      calc_b_reg    <= calc_b_next;
      calc_load_reg <= calc_load_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    beats_next     = beats_reg;
    issued_next    = issued_reg;
    returned_next  = returned_reg;
    acc_next       = acc_reg;
    calc_a_next    = calc_a_reg;
    calc_b_next    = calc_b_reg;
    calc_load_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          beats_next    = num_beats;
          acc_next      = '0;
          issued_next   = '0;
          returned_next = '0;
          state_next    = (num_beats == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          calc_a_next    = op_a;
          calc_b_next    = op_b;
          calc_load_next = 1'b1;
          issued_next    = issued_reg + CNT_W'(1);
          if (issued_reg + CNT_W'(1) == beats_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The final return closes the job whether it lands in FEED or DRAIN.
    if (beat_return) begin
      acc_next      = acc_reg + ACC_W'(calc_sum);
      returned_next = returned_reg + CNT_W'(1);
      if (returned_reg + CNT_W'(1) == beats_reg) state_next = DONE;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign res_valid = (state_reg == DONE);
  assign res_data  = acc_reg;
  assign calc_a    = calc_a_reg;
  assign calc_b    = calc_b_reg;
  assign calc_load = calc_load_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomised job bench for calc_sequencer: a delay-line datapath model feeds
// back chosen per-beat sums and each job result is compared to their total.
module tb_calc_sequencer;

  localparam int DATA_W   = 128;
  localparam int SUM_W    = 20;
  localparam int CALC_LAT = 2;
  localparam int CNT_W    = 8;
  localparam int ACC_W    = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_beats;
  logic              busy;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] calc_a;
  logic [DATA_W-1:0] calc_b;
  logic              calc_load;
  logic [SUM_W-1:0]  calc_sum;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  calc_sequencer #(
    .DATA_W   (DATA_W),
    .SUM_W    (SUM_W),
    .CALC_LAT (CALC_LAT),
    .CNT_W    (CNT_W),
    .ACC_W    (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_beats (num_beats),
    .busy      (busy),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .calc_a    (calc_a),
    .calc_b    (calc_b),
    .calc_load (calc_load),
    .calc_sum  (calc_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  int posedge_cnt = 0;
  always @(posedge clk) posedge_cnt <= posedge_cnt + 1;

  // Datapath model: the k-th load ever seen returns sum_tab[k] CALC_LAT cycles later.
  logic [SUM_W-1:0] sum_tab [4096];
  logic [SUM_W-1:0] dp_pipe [CALC_LAT];
  int               total_loads = 0;

  always @(posedge clk) begin
    dp_pipe[0] <= calc_load ? sum_tab[total_loads % 4096] : SUM_W'($urandom);
    for (int i = 1; i < CALC_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    if (calc_load) total_loads <= total_loads + 1;
  end
  assign calc_sum = dp_pipe[CALC_LAT-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [SUM_W-1:0]  job_val [256];
  logic [DATA_W-1:0] last_a = '0;
  logic [DATA_W-1:0] last_b = '0;

  function automatic logic [DATA_W-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts in the current (post-negedge) cycle, ends at the negedge after the result handshake.
  // mode: 0 = op_valid held high, 1 = toggling 1,0,1,..., 2 = random.
  task automatic run_job(input string tag, input int n, input int mode, input int exp_lat,
                         input int hold, input int inj_cycle, input bit start_in_done);
    int               base;
    bit               acc_prev;
    bit               done;
    logic [ACC_W-1:0] exp_sum;
    base    = total_loads;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      sum_tab[(base + i) % 4096] = job_val[i];
      exp_sum += ACC_W'(job_val[i]);
    end
    start     = 1'b1;
    num_beats = CNT_W'(n);
    acc_prev  = 1'b0;
    done      = 1'b0;
    for (int c = 1; c <= 2000 && !done; c++) begin
      @(negedge clk);
      start = (c == inj_cycle);
      if (start) num_beats = CNT_W'(n + 5);
      check({tag, "_calc_load"}, DATA_W'(calc_load), DATA_W'(acc_prev));
      check({tag, "_calc_a"}, calc_a, last_a);
      check({tag, "_calc_b"}, calc_b, last_b);
      if (res_valid) begin
        if (exp_lat >= 0) check({tag, "_latency"}, DATA_W'(c), DATA_W'(exp_lat));
        check({tag, "_res_data"}, DATA_W'(res_data), DATA_W'(exp_sum));
        check({tag, "_loads"}, DATA_W'(total_loads - base), DATA_W'(n));
        op_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check({tag, "_hold_valid"}, DATA_W'(res_valid), DATA_W'(1));
          check({tag, "_hold_data"}, DATA_W'(res_data), DATA_W'(exp_sum));
        end
        res_ready = 1'b1;
        start     = start_in_done;
        if (start_in_done) num_beats = CNT_W'(n + 7);
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_busy_after"}, DATA_W'(busy), DATA_W'(0));
        check({tag, "_valid_after"}, DATA_W'(res_valid), DATA_W'(0));
        done = 1'b1;
      end else begin
        case (mode)
          0:       op_valid = 1'b1;
          1:       op_valid = (c % 2 == 1);
          default: op_valid = 1'($urandom_range(0, 1));
        endcase
        op_a     = rand_vec();
        op_b     = rand_vec();
        acc_prev = op_valid && op_ready;
        if (acc_prev) begin
          last_a = op_a;
          last_b = op_b;
        end
      end
    end
    if (!done) check({tag, "_timeout"}, DATA_W'(0), DATA_W'(1));
    op_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    num_beats = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    #1;
    check("rst_busy", DATA_W'(busy), DATA_W'(0));
    check("rst_op_ready", DATA_W'(op_ready), DATA_W'(0));
    check("rst_calc_load", DATA_W'(calc_load), DATA_W'(0));
    check("rst_res_valid", DATA_W'(res_valid), DATA_W'(0));
    check("rst_res_data", DATA_W'(res_data), DATA_W'(0));
    check("rst_calc_a", calc_a, DATA_W'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    job_val[0] = 20'h00ABC;
    run_job("single", 1, 0, 5, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) job_val[i] = SUM_W'(i + 1);
    run_job("b2b", 4, 0, 8, 0, 0, 1'b0);

    for (int i = 0; i < 3; i++) job_val[i] = SUM_W'($urandom);
    run_job("bubbles", 3, 1, -1, 5, 0, 1'b0);

    run_job("zero", 0, 0, 1, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) job_val[i] = SUM_W'($urandom);
    run_job("start_in_feed", 4, 0, 8, 0, 2, 1'b1);

    for (int i = 0; i < 5; i++) job_val[i] = SUM_W'($urandom);
    run_job("after_done_start", 5, 2, -1, 0, 0, 1'b0);

    for (int i = 0; i < 255; i++) job_val[i] = 20'hFFFFF;
    run_job("max_len", 255, 0, 259, 0, 0, 1'b0);

    // Abort a job while it drains, then make sure stale sums never surface.
    for (int i = 0; i < 3; i++) sum_tab[(total_loads + i) % 4096] = SUM_W'($urandom);
    start     = 1'b1;
    num_beats = CNT_W'(3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start    = 1'b0;
      op_valid = (c <= 3);
      op_a     = rand_vec();
      op_b     = rand_vec();
    end
    check("drain_op_ready", DATA_W'(op_ready), DATA_W'(0));
    check("drain_busy", DATA_W'(busy), DATA_W'(1));
    #2 rst = 1'b1;
    #1;
    check("abort_busy", DATA_W'(busy), DATA_W'(0));
    check("abort_op_ready", DATA_W'(op_ready), DATA_W'(0));
    check("abort_calc_load", DATA_W'(calc_load), DATA_W'(0));
    check("abort_res_valid", DATA_W'(res_valid), DATA_W'(0));
    @(negedge clk);
    rst    = 1'b0;
    last_a = '0;
    last_b = '0;
    check("abort_calc_a", calc_a, last_a);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_no_result", DATA_W'(res_valid), DATA_W'(0));
    end

    for (int i = 0; i < 6; i++) job_val[i] = SUM_W'($urandom);
    run_job("post_reset", 6, 0, 10, 0, 0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) job_val[i] = SUM_W'($urandom);
      run_job("random", n, 2, -1, $urandom_range(0, 3), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Job controller in front of the 4-bit-sliced dot-product datapath.
- Accepts a job of N operand-vector pairs and streams them into the datapath at up to one pair per cycle over a valid/ready interface.
- Tracks in-flight beats through the fixed datapath latency and accumulates the N per-beat sums into one wide result.
- Presents that result over a valid/ready interface, for use by a surrounding systolic-array top level.

Parameters:
- DATA_W, 128, width of each operand vector (16 lanes x 8 bits).
- SUM_W, 20, width of the datapath per-beat sum.
- CALC_LAT, 2, cycles from a calc_load-high cycle to the matching calc_sum being valid; must be >= 1.
- CNT_W, 8, width of the beat counters and num_beats.
- ACC_W, 28, accumulator width; must be >= SUM_W + CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock domain, asynchronous assertion, active-high; clears all state.
- start  in  1  job request; sampled only in IDLE.
- num_beats  in  CNT_W  beats in the job; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- op_valid  in  1  upstream operand pair valid.
- op_ready  out  1  sequencer can accept an operand pair.
- op_a  in  DATA_W  operand vector A.
- op_b  in  DATA_W  operand vector B.
- calc_a  out  DATA_W  registered A to the datapath.
- calc_b  out  DATA_W  registered B to the datapath.
- calc_load  out  1  operand-load strobe to the datapath.
- calc_sum  in  SUM_W  datapath per-beat sum.
- res_valid  out  1  accumulated result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  ACC_W  accumulated result.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters, accumulator and tag pipe cleared.
- Reset mid-job: in-flight beats are discarded; no res_valid is produced for the aborted job.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 latches num_beats and clears acc, issued and returned.
  - num_beats=0: go to DONE; res_data=0 and res_valid=1 in the next cycle.
  - Otherwise go to FEED.
  - start is ignored in every other state.
- FEED: op_ready = (issued < num_beats).
  - Accept = op_valid & op_ready.
  - On accept: calc_a<=op_a, calc_b<=op_b, calc_load<=1, issued++.
  - Without accept: calc_load<=0, and calc_a/calc_b hold their values.
  - When the accept makes issued reach num_beats, go to DRAIN.
  - Throughput: one beat per cycle; upstream bubbles are allowed at any time.
- Tag pipe: a CALC_LAT-deep shift register of calc_load.
  - Its output high means calc_sum belongs to a live beat.
  - On that edge: acc <= acc + zero-extended calc_sum, returned++.
- DRAIN: op_ready=0. When a returning beat makes returned reach num_beats, go to DONE.
  - The same rule applies if the last return lands while still in FEED.
- DONE: res_valid=1, res_data=acc, both held stable until res_ready=1; on that handshake go to IDLE.
  - res_ready in any other state is ignored.
- Latency with op_valid held high:
  - start accepted in cycle 0, FEED in cycle 1, beats accepted in cycles 1..N.
  - res_valid first high in cycle N+2+CALC_LAT.
- No overflow is possible given the ACC_W constraint; an elaboration-time check enforces that constraint.
- busy falls in the cycle after the DONE handshake.

Decomposition:
- Shared package calc_pkg holds:
  - DATA_W and SUM_W defaults.
  - The 2-bit state encoding (IDLE=0, FEED=1, DRAIN=2, DONE=3).
  - A localparam for the sequencer's internal load-register stage (1 cycle).
- One sub-module: calc_tag_pipe, a parameterised CALC_LAT-stage valid shift register with async active-high reset.

Test Plan:
The bench models the datapath as a CALC_LAT-cycle delay that returns calc_sum = per-beat value chosen by the bench.
- Single beat: start, num_beats=1, op_valid=1, model sum 0x00ABC -> res_valid first high in cycle 5, res_data=0x00ABC.
- Back-to-back: num_beats=4, op_valid held high, sums 1, 2, 3, 4 -> calc_load high for 4 consecutive cycles, res_data=10, res_valid in cycle 8.
- Bubbles and backpressure:
  - num_beats=3 with op_valid toggling 1,0,1,0,1 -> exactly 3 calc_load pulses, res_data = sum of the 3 values.
  - Holding res_ready=0 for 5 cycles keeps res_valid and res_data stable.
- Zero and maximum length:
  - num_beats=0 -> res_data=0 and res_valid one cycle after start, with no calc_load pulse.
  - num_beats=255 with every sum 0xFFFFF -> res_data=0x0FEFFF01, no wrap.
- Ignored start: start pulsed during FEED with a different num_beats -> job length unchanged; start pulsed in DONE together with res_ready -> ignored, and a new start one cycle later is accepted.
- Reset mid-DRAIN: assert rst asynchronously between edges -> busy, op_ready, calc_load and res_valid go to 0 immediately; late model sums after release do not produce a result, and the next job returns the correct value.
